systolic_feeder: RTL

Input-side driver for the N×N systolic array `top`. It accepts the two operand matrices as N unskewed vectors over a valid/ready handshake and buffers them. It then replays them onto the array's `in_a`/`in_b` lanes with the diagonal skew the array requires, and pulses `en_in` after the last skewed word. It holds off the next matrix pair until the array reports completion on `en_out`.

---
 rtl/systolic_feeder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder
//
// Input-side driver for an N x N systolic array. Operand matrices arrive as
// N unskewed vectors over a valid/ready handshake and are buffered. They are
// then replayed onto the array lanes with a diagonal skew: lane j is delayed
// by j steps. A one-cycle end-of-operands strobe follows the skewed words.
// The next matrix pair is not accepted until the array signals completion.
//
// Ports
//   clk      : single clock, rising-edge
//   reset    : asynchronous, active-high; clears all control state and outputs
//   s_valid  : upstream vector valid
//   s_ready  : feeder can accept a vector (LOAD state, reset deasserted)
//   s_a      : vector k of A, lane j = A[j][k]
//   s_b      : vector k of B, lane j = B[k][j]
//   in_a     : skewed A lanes to the array (registered)
//   in_b     : skewed B lanes to the array (registered)
//   en_in    : end-of-operands strobe to the array (registered)
//   en_out   : array done strobe; only honoured while waiting

module systolic_feeder #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [8*N-1:0] s_a,
  input  logic [8*N-1:0] s_b,
  output logic [8*N-1:0] in_a,
  output logic [8*N-1:0] in_b,
  output logic           en_in,
  input  logic           en_out
);

  localparam int LW = $clog2(N);
  localparam int TW = $clog2(2 * N);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  logic [1:0]     r_state;
  logic [LW-1:0]  r_lcnt;
  logic [TW-1:0]  r_t;
  logic [8*N-1:0] r_bufA [N];
  logic [8*N-1:0] r_bufB [N];

  logic           w_accept;
  logic           w_lastLoad;
  logic           w_lastStep;
  logic [TW-1:0]  w_nextStep;
  logic [8*N-1:0] w_skewA;
  logic [8*N-1:0] w_skewB;

  assign s_ready    = (r_state == ST_LOAD) && !reset;
  assign w_accept   = s_valid && s_ready;
  assign w_lastLoad = w_accept && (r_lcnt == LW'(N - 1));
  assign w_lastStep = (r_t == TW'(2 * N - 2));

  // r_t is the step currently on the outputs. The output registers are loaded
  // one step ahead: step 0 on the final load handshake, then t+1 while
  // streaming.
  assign w_nextStep = (r_state == ST_STREAM) ? (r_t + 1'b1) : '0;

  // Both buffers are stored as received vectors. For step s, lane j needs
  // vector k = s - j of either buffer, lane j, which gives A[j][k] and B[k][j].
  always_comb begin
    w_skewA = '0;
    w_skewB = '0;
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) begin
        if (w_nextStep == TW'(j + k)) begin
          w_skewA[8*j +: 8] = r_bufA[k][8*j +: 8];
          w_skewB[8*j +: 8] = r_bufB[k][8*j +: 8];
        end
      end
    end
  end

  // Operand storage. Contents are don't-care after reset, so these registers
  // carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_bufA[r_lcnt] <= s_a;
      r_bufB[r_lcnt] <= s_b;
    end
  end

  // Control FSM and registered lane outputs. Lanes and en_in default to zero
  // every cycle and are only populated while streaming or flushing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_LOAD;
      r_lcnt  <= '0;
      r_t     <= '0;
      in_a    <= '0;
      in_b    <= '0;
      en_in   <= 1'b0;
    end else begin
      in_a  <= '0;
      in_b  <= '0;
      en_in <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            if (w_lastLoad) begin
              r_state <= ST_STREAM;
              r_lcnt  <= '0;
              r_t     <= '0;
              in_a    <= w_skewA;
              in_b    <= w_skewB;
            end else begin
              r_lcnt <= r_lcnt + 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (w_lastStep) begin
            r_state <= ST_FLUSH;
            r_t     <= '0;
            en_in   <= 1'b1;
          end else begin
            r_t  <= r_t + 1'b1;
            in_a <= w_skewA;
            in_b <= w_skewB;
          end
        end
        ST_FLUSH: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (en_out) begin
            r_state <= ST_LOAD;
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule
